// File: rtl/rv32i_text_render_if.sv
// Bundle of the command, font-bus and pixel-stream signals of the text renderer.
// The slave modport is the renderer's view; the master modport is the
// surrounding system (command source, font responder and pixel sink).
interface rv32i_text_render_if;
    // Command channel (valid/ready: a command transfers on the rising clock
    // edge where cmd_valid && cmd_ready; the source holds its fields until then).
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_char;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    // Font bus: fixed one-cycle read latency, read-only
    logic        font_cs;
    logic        font_we;
    logic [31:0] font_addr;
    logic [31:0] font_data;
    // Pixel channel (valid/ready: a pixel transfers on the rising clock edge
    // where pix_valid && pix_ready; pix_x/pix_y/pix_on hold until then)
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_on;
    // Status
    logic        busy;
    logic        done;

    modport slave (
        input  cmd_valid, cmd_char, cmd_x, cmd_y, font_data, pix_ready,
        output cmd_ready, font_cs, font_we, font_addr, pix_valid, pix_x, pix_y,
        output pix_on, busy, done
    );

    modport master (
        output cmd_valid, cmd_char, cmd_x, cmd_y, font_data, pix_ready,
        input  cmd_ready, font_cs, font_we, font_addr, pix_valid, pix_x, pix_y,
        input  pix_on, busy, done
    );
endinterface

// File: rtl/rv32i_text_render.sv
// Character renderer: fetches the 12 columns of a 16x12 glyph from the font
// responder one column at a time and streams its 192 pixels (column-major,
// top row first) to the pixel sink.
// Optional feature macro TEXT_RENDER_TRANSPARENT_EN: background pixels are
// skipped (no handshake) instead of emitted with pix_on=0.
module rv32i_text_render #(
    parameter logic [31:0] FONT_BASE = 32'hE0001000
) (
    input  logic                       clk,
    input  logic                       rst,
    rv32i_text_render_if.slave         bus,
    output logic [2:0]                 o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_char;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [3:0]  r_col;
    logic [3:0]  r_row;
    logic [15:0] r_colreg;
    logic        w_bit;
    logic        w_beat;
    logic        w_accept;

    // Bit 15 of a column word is the glyph's top row
    assign w_bit        = r_colreg[4'd15 - r_row];
    assign w_accept     = bus.cmd_valid && (r_state == S_IDLE);
    assign bus.font_we  = 1'b0;
    assign o_state      = r_state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and output decode; every output is zero outside its own state
    always_comb begin
        w_next        = r_state;
        w_beat        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.font_cs   = 1'b0;
        bus.font_addr = 32'd0;
        bus.pix_valid = 1'b0;
        bus.pix_x     = 10'd0;
        bus.pix_y     = 10'd0;
        bus.pix_on    = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.busy      = 1'b0;
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) w_next = S_REQ;
            end
            S_REQ: begin
                bus.font_cs   = 1'b1;
                bus.font_addr = FONT_BASE + {20'd0, r_char, 5'd0} + {27'd0, r_col, 1'b0};
                w_next        = S_CAP;
            end
            S_CAP: begin
                w_next = S_EMIT;
            end
            S_EMIT: begin
                // 10-bit adds wrap the coordinates modulo 1024
                bus.pix_x  = r_x + {6'd0, r_col};
                bus.pix_y  = r_y + {6'd0, r_row};
                bus.pix_on = w_bit;
`ifdef TEXT_RENDER_TRANSPARENT_EN
                bus.pix_valid = w_bit;
                w_beat        = w_bit ? bus.pix_ready : 1'b1;
`else
                bus.pix_valid = 1'b1;
                w_beat        = bus.pix_ready;
`endif
                if (w_beat && (r_row == 4'd15))
                    w_next = (r_col == 4'd11) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command latch, glyph column capture and column/row walk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_char   <= 7'd0;
            r_x      <= 10'd0;
            r_y      <= 10'd0;
            r_col    <= 4'd0;
            r_row    <= 4'd0;
            r_colreg <= 16'd0;
        end else begin
            if (w_accept) begin
                // Control codes render as a space
                r_char <= (bus.cmd_char < 7'd32) ? 7'd32 : bus.cmd_char;
                r_x    <= bus.cmd_x;
                r_y    <= bus.cmd_y;
                r_col  <= 4'd0;
                r_row  <= 4'd0;
            end
            if (r_state == S_CAP)
                r_colreg <= bus.font_data[15:0];
            if ((r_state == S_EMIT) && w_beat) begin
                if (r_row == 4'd15) begin
                    r_row <= 4'd0;
                    if (r_col != 4'd11) r_col <= r_col + 4'd1;
                end else begin
                    r_row <= r_row + 4'd1;
                end
            end
        end
    end

endmodule
